// File: rtl/ram_writer_pkg.sv
// Shared types and default sizes for the burst RAM writer.
package ram_writer_pkg;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W      = 5;
  localparam int SUM_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ram_writer_if.sv
// Request, producer stream, RAM write port and status bundle of the burst writer.
interface ram_writer_if
  import ram_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  count;
  logic [SUM_W-1:0]  checksum;
  logic              err;

  modport master (
    output start, len, base_addr, in_valid, in_data,
    input  in_ready, ram_we, ram_addr, ram_data, busy, done, count, checksum, err
  );

  modport slave (
    input  start, len, base_addr, in_valid, in_data,
    output in_ready, ram_we, ram_addr, ram_data, busy, done, count, checksum, err
  );
endinterface

// File: rtl/FA_sixteen.sv
// 16-bit adder used for the running checksum; carry out is dropped (mod 2^16).
module FA_sixteen (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] S
);
  assign S = A + B;
endmodule

// File: rtl/ram_writer.sv
// Accepts a burst of len bytes from a valid/ready producer and writes them to
// consecutive RAM addresses starting at base_addr, accumulating a checksum.
//
// state | meaning
// IDLE  | waiting for start; illegal len or stray start pulses err
// LOAD  | accepting bytes while count < len, one RAM write per handshake
// DONE  | last write issued this cycle; done pulses, then back to IDLE
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ram_writer_if.slave bus
);
  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] base_q;
  logic [SUM_W-1:0]  sum_next;
  logic              legal_len;
  logic              hs;
  logic              last_hs;
  logic              accept_start;

  assign legal_len    = (bus.len != '0) && (bus.len <= LEN_W'(DEPTH));
  assign accept_start = (state_q == IDLE) && bus.start && legal_len;
  assign bus.in_ready = (state_q == LOAD) && (bus.count < len_q);
  assign hs           = bus.in_valid && bus.in_ready;
  assign last_hs      = hs && (bus.count == (len_q - LEN_W'(1)));

  FA_sixteen u_sum (
    .A (bus.checksum),
    .B (SUM_W'(bus.in_data)),
    .S (sum_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_start) state_d = LOAD;
      LOAD:    if (last_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      base_q       <= '0;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_data <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.count    <= '0;
      bus.checksum <= '0;
    end else begin
      state_q    <= state_d;
      bus.ram_we <= hs;
      bus.busy   <= (state_d != IDLE);
      bus.done   <= (state_d == DONE);
      // any start outside IDLE is a protocol error, as is an out-of-range len
      bus.err    <= bus.start && ((state_q != IDLE) || !legal_len);
      if (accept_start) begin
        len_q        <= bus.len;
        base_q       <= bus.base_addr;
        bus.count    <= '0;
        bus.checksum <= '0;
      end
      if (hs) begin
        bus.ram_addr <= base_q + ADDR_W'(bus.count);
        bus.ram_data <= bus.in_data;
        bus.count    <= bus.count + LEN_W'(1);
        bus.checksum <= sum_next;
      end
    end
  end
endmodule

// File: tb/tb_ram_writer.sv
// Directed bench for ram_writer with a RAM mirror built from observed writes.
module tb_ram_writer;
  logic clk = 1'b0;
  logic reset;

  ram_writer_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  ram_writer #(.DEPTH(16), .ADDR_W(10), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:1023];
  int we_cnt, done_cnt, err_cnt;
  int addr_q[$];
  int data_q[$];

  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      mem[bus.ram_addr] = bus.ram_data;
      we_cnt++;
      addr_q.push_back(int'(bus.ram_addr));
      data_q.push_back(int'(bus.ram_data));
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.err === 1'b1) err_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic clear_mon();
    we_cnt = 0; done_cnt = 0; err_cnt = 0;
    addr_q.delete(); data_q.delete();
  endtask

  task automatic start_burst(input int l, input int b);
    @(negedge clk);
    bus.start = 1'b1; bus.len = 5'(l); bus.base_addr = 10'(b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns right after the posedge on which the handshake happens.
  task automatic push(input logic [7:0] d, input int gap);
    int t;
    repeat (gap) begin @(negedge clk); bus.in_valid = 1'b0; end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL push_ready: in_ready=%b never 1 for data %0h", bus.in_ready, d);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic test_readback(input int b, input int l);
    int s = 0;
    for (int i = 0; i < l; i++) s += int'(mem[(b + i) % 1024]);
    checks++;
    if (16'(s) !== bus.checksum) begin errors++; $display("FAIL readback_sum: checksum=%0h mirror_sum=%0h", bus.checksum, 16'(s)); end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.len = '0; bus.base_addr = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 10'd0) begin errors++; $display("FAIL rst_ram_addr: got %0h want 0", bus.ram_addr); end
    checks++; if (bus.ram_data !== 8'd0) begin errors++; $display("FAIL rst_ram_data: got %0h want 0", bus.ram_data); end
    checks++; if ({bus.in_ready, bus.busy, bus.done, bus.err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {bus.in_ready, bus.busy, bus.done, bus.err}); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    checks++; if (bus.checksum !== 16'd0) begin errors++; $display("FAIL rst_checksum: got %0h want 0", bus.checksum); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_mon();
    start_burst(4, 0);
    for (int i = 0; i < 4; i++) push(8'(i + 1), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done_timing: got %b want 1", bus.done); end
    checks++; if ({bus.ram_we, bus.ram_addr, bus.ram_data} !== {1'b1, 10'd3, 8'd4}) begin errors++; $display("FAIL basic_last_write: we=%b addr=%0d data=%0d want 1/3/4", bus.ram_we, bus.ram_addr, bus.ram_data); end
    checks++; if ({bus.in_ready, bus.busy} !== 2'b01) begin errors++; $display("FAIL basic_done_flags: ready/busy=%b want 01", {bus.in_ready, bus.busy}); end
    @(negedge clk);
    checks++; if ({bus.done, bus.busy, bus.ram_we} !== 3'b000) begin errors++; $display("FAIL basic_idle_flags: done/busy/we=%b want 000", {bus.done, bus.busy, bus.ram_we}); end
    checks++; if (bus.ram_addr !== 10'd3) begin errors++; $display("FAIL basic_addr_hold: got %0d want 3", bus.ram_addr); end
    checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL basic_count: got %0d want 4", bus.count); end
    checks++; if (bus.checksum !== 16'd10) begin errors++; $display("FAIL basic_checksum: got %0d want 10", bus.checksum); end
    checks++; if (we_cnt != 4 || done_cnt != 1) begin errors++; $display("FAIL basic_pulses: we=%0d done=%0d want 4/1", we_cnt, done_cnt); end
    for (int i = 0; i < 4; i++) begin
      int a, d;
      a = (i < addr_q.size()) ? addr_q[i] : -1;
      d = (i < data_q.size()) ? data_q[i] : -1;
      checks++; if (a != i || d != i + 1) begin errors++; $display("FAIL basic_write%0d: addr=%0d data=%0d want %0d/%0d", i, a, d, i, i + 1); end
    end
    test_readback(0, 4);
  endtask

  task automatic test_wrap();
    clear_mon();
    start_burst(16, 1020);
    for (int i = 0; i < 16; i++) push(8'hFF, i % 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", bus.done); end
    @(negedge clk);
    checks++; if (we_cnt != 16 || done_cnt != 1) begin errors++; $display("FAIL wrap_pulses: we=%0d done=%0d want 16/1", we_cnt, done_cnt); end
    checks++; if (bus.checksum !== 16'h0FF0) begin errors++; $display("FAIL wrap_checksum: got %0h want 0ff0", bus.checksum); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL wrap_count: got %0d want 16", bus.count); end
    for (int i = 0; i < 16; i++) begin
      int a;
      a = (i < addr_q.size()) ? addr_q[i] : -1;
      checks++; if (a != (1020 + i) % 1024) begin errors++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, a, (1020 + i) % 1024); end
    end
    test_readback(1020, 16);
  endtask

  task automatic test_illegal();
    clear_mon();
    start_burst(0, 5);
    checks++; if ({bus.err, bus.busy, bus.in_ready} !== 3'b100) begin errors++; $display("FAIL illegal_len0: err/busy/ready=%b want 100", {bus.err, bus.busy, bus.in_ready}); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_err_width: got %b want 0", bus.err); end
    start_burst(17, 5);
    checks++; if ({bus.err, bus.busy} !== 2'b10) begin errors++; $display("FAIL illegal_len17: err/busy=%b want 10", {bus.err, bus.busy}); end
    checks++; if (bus.count !== 5'd16 || bus.checksum !== 16'h0FF0) begin errors++; $display("FAIL illegal_hold: count=%0d checksum=%0h want 16/0ff0", bus.count, bus.checksum); end
    repeat (2) @(negedge clk);
    checks++; if ({bus.in_ready, bus.busy} !== 2'b00) begin errors++; $display("FAIL illegal_stays_idle: ready/busy=%b want 00", {bus.in_ready, bus.busy}); end
    checks++; if (we_cnt != 0 || err_cnt != 2) begin errors++; $display("FAIL illegal_pulses: we=%0d err=%0d want 0/2", we_cnt, err_cnt); end
  endtask

  task automatic test_start_mid_load();
    clear_mon();
    start_burst(8, 100);
    for (int i = 0; i < 3; i++) push(8'(10 + i), 0);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.start = 1'b1; bus.len = 5'd3; bus.base_addr = 10'd500;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if ({bus.err, bus.busy} !== 2'b11) begin errors++; $display("FAIL midload_err: err/busy=%b want 11", {bus.err, bus.busy}); end
    for (int i = 3; i < 8; i++) push(8'(10 + i), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.ram_addr !== 10'd107) begin errors++; $display("FAIL midload_done: done=%b addr=%0d want 1/107", bus.done, bus.ram_addr); end
    @(negedge clk);
    checks++; if (we_cnt != 8 || done_cnt != 1 || err_cnt != 1) begin errors++; $display("FAIL midload_pulses: we=%0d done=%0d err=%0d want 8/1/1", we_cnt, done_cnt, err_cnt); end
    checks++; if (bus.count !== 5'd8 || bus.checksum !== 16'd108) begin errors++; $display("FAIL midload_totals: count=%0d checksum=%0d want 8/108", bus.count, bus.checksum); end
    test_readback(100, 8);
  endtask

  task automatic test_reset_abort();
    clear_mon();
    start_burst(6, 200);
    push(8'h21, 0);
    push(8'h22, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'h33; reset = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ram_we, bus.in_ready, bus.busy, bus.done, bus.err} !== 5'b0) begin errors++; $display("FAIL abort_flags: we/ready/busy/done/err=%b want 00000", {bus.ram_we, bus.in_ready, bus.busy, bus.done, bus.err}); end
    checks++; if (bus.ram_addr !== 10'd0 || bus.ram_data !== 8'd0) begin errors++; $display("FAIL abort_bus: addr=%0d data=%0h want 0/0", bus.ram_addr, bus.ram_data); end
    checks++; if (bus.count !== 5'd0 || bus.checksum !== 16'd0) begin errors++; $display("FAIL abort_totals: count=%0d checksum=%0h want 0/0", bus.count, bus.checksum); end
    reset = 1'b0; bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (we_cnt != 2 || done_cnt != 0) begin errors++; $display("FAIL abort_pulses: we=%0d done=%0d want 2/0", we_cnt, done_cnt); end
    start_burst(2, 300);
    push(8'h40, 0);
    push(8'h41, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL abort_next_done: got %b want 1", bus.done); end
    @(negedge clk);
    checks++; if (we_cnt != 4 || done_cnt != 1) begin errors++; $display("FAIL abort_next_pulses: we=%0d done=%0d want 4/1", we_cnt, done_cnt); end
    checks++; if (bus.count !== 5'd2 || bus.checksum !== 16'h0081) begin errors++; $display("FAIL abort_next_totals: count=%0d checksum=%0h want 2/81", bus.count, bus.checksum); end
    checks++; if (mem[300] !== 8'h40 || mem[301] !== 8'h41) begin errors++; $display("FAIL abort_next_mem: %0h %0h want 40 41", mem[300], mem[301]); end
    test_readback(300, 2);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_wrap();
    test_illegal();
    test_start_mid_load();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_writer.md
RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 Parameter DEPTH, default 16: maximum entries written per burst.
REQ-002 Parameter ADDR_W, default 10: RAM address width.
REQ-003 Parameter DATA_W, default 8: RAM data width.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  burst request, sampled only in IDLE.
REQ-007 len  in  5  burst length in entries, valid range 1..DEPTH.
REQ-008 base_addr  in  ADDR_W  first RAM address of burst.
REQ-009 in_valid  in  1  producer has a byte on in_data.
REQ-010 in_data  in  DATA_W  byte to store.
REQ-011 in_ready  out  1  writer accepts in_data this cycle.
REQ-012 ram_we  out  1  RAM write enable, drives RAM wr_en.
REQ-013 ram_addr  out  ADDR_W  RAM address.
REQ-014 ram_data  out  DATA_W  RAM write data.
REQ-015 busy  out  1  high in LOAD and DONE.
REQ-016 done  out  1  one-cycle pulse after the last write of a burst.
REQ-017 count  out  5  entries accepted in current/last burst.
REQ-018 checksum  out  16  sum of bytes accepted in current/last burst.
REQ-019 err  out  1  one-cycle pulse on an illegal request.

Function
REQ-020 FSM states: IDLE, LOAD, DONE.
REQ-021 IDLE: in_ready=0; start with len in 1..DEPTH -> LOAD next cycle; latch len and base_addr; clear count and checksum.
REQ-022 IDLE: start with len=0 or len>DEPTH -> err=1 next cycle; stay IDLE; count and checksum unchanged.
REQ-023 LOAD: in_ready=1 while count<len; handshake = in_valid & in_ready.
REQ-024 Handshake in cycle N -> cycle N+1: ram_we=1, ram_addr=(base_addr+count_at_N) mod 2^ADDR_W, ram_data=in_data sampled at N.
REQ-025 ram_we=0 in every cycle not following a handshake; ram_addr and ram_data hold last value.
REQ-026 Each handshake: count+1; checksum = (checksum + zero-extended in_data) mod 2^16.
REQ-027 Handshake with count_at_N = len-1 -> DONE in cycle N+1, same cycle as last ram_we; in_ready=0 from N+1.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; count and checksum hold until next legal start.
REQ-029 start while in LOAD or DONE -> ignored, err=1 next cycle; burst continues unaffected.
REQ-030 in_valid low in LOAD -> wait indefinitely; no timeout.
REQ-031 Address wrap: base_addr+index past 2^ADDR_W-1 wraps to 0; no error.
REQ-032 All outputs registered except in_ready, which decodes from state and count.

Reset
REQ-033 reset=1 at a posedge -> next cycle: IDLE, ram_we=0, ram_addr=0, ram_data=0, in_ready=0, busy=0, done=0, err=0, count=0, checksum=0.
REQ-034 reset during LOAD aborts the burst: no done, no further ram_we, and a pending handshake is not written.
REQ-035 reset has priority over start, in_valid and all FSM transitions.

Structure
REQ-036 Shared package holds the state enum (IDLE/LOAD/DONE), DEPTH, ADDR_W and DATA_W defaults.
REQ-037 Checksum addition is implemented by instantiating FA_sixteen (A=checksum, B={8'd0,in_data}); no other sub-modules.
REQ-038 RAM is external; ram_we/ram_addr/ram_data connect directly to basic_ram wr_en/addr/data_in.

Verification
REQ-039 Reset, then start, len=4, base=0, bytes 1,2,3,4 back-to-back -> ram_we high 4 cycles at addr 0..3 with data 1..4; done one cycle after the 4th handshake; count=4, checksum=10.
REQ-040 len=16, base=1020, bytes 0xFF x16 with in_valid toggling -> addresses 1020..1023,0..11; checksum=0x0FF0; exactly 16 ram_we pulses.
REQ-041 start with len=0, then start with len=17 -> err pulse each time; FSM stays IDLE; ram_we never asserts.
REQ-042 start asserted mid-LOAD (len=8, after 3 bytes) -> err pulse; burst completes with 8 writes and one done.
REQ-043 reset asserted after 2 of 6 bytes -> no done, no further ram_we; all outputs 0 next cycle; new len=2 burst then completes normally.
REQ-044 Scoreboard mirrors the RAM and checks a subsequent accumulator read-back sum against checksum.
